// File: rtl/led_seq_pkg.sv
// Shared encodings and defaults for the LED state sequencer.
package led_seq_pkg;

   localparam int unsigned MODE_W           = 2;
   localparam int unsigned TICK_DIV_DEFAULT = 25_000_000;

   // Step mode selected on the mode input
   typedef enum logic [MODE_W-1:0] {
      MODE_UP       = 2'b00,
      MODE_DOWN     = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_e;

   // Ping-pong travel direction
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/led_seq_prescaler.sv
// Clock-enable prescaler: counts 0..TICK_DIV-1 while enabled and flags terminal count.
module led_seq_prescaler
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
)(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tc;

   assign w_tc = (r_cnt == TC);

   // Counter: clear wins, otherwise advance and roll over at terminal count while enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_tc ? '0 : r_cnt + CNT_W'(1);
      end
   end

   // Tick is combinational so the state register updates on the terminal-count edge
   assign tick = en & w_tc;

endmodule

// File: rtl/led_seq_stepper.sv
// Timed state sequencer for the LED panel: steps state through [FIRST, LAST]
// in up, down, ping-pong or hold mode at one step per TICK_DIV clocks.
// Optional feature macro: LED_SEQ_MANUAL_STEP_EN adds a step_req input that
// single-steps the sequence while en is low.
module led_seq_stepper
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
   parameter int unsigned STATE_W  = 8,
   parameter int unsigned FIRST    = 11,
   parameter int unsigned LAST     = 62
)(
   input  logic               clk,
   input  logic               rst,
`ifdef LED_SEQ_MANUAL_STEP_EN
   input  logic               step_req,
`endif
   input  logic               en,
   input  logic [MODE_W-1:0]  mode,
   input  logic               restart,
   output logic [STATE_W-1:0] state,
   output logic               step_tick,
   output logic               wrap
);

   localparam logic [STATE_W-1:0] S_FIRST = STATE_W'(FIRST);
   localparam logic [STATE_W-1:0] S_LAST  = STATE_W'(LAST);

   // Parameter legality, caught at elaboration
   if (TICK_DIV < 1) begin : g_bad_tick_div
      $error("led_seq_stepper: TICK_DIV must be >= 1");
   end
   if (FIRST >= LAST) begin : g_bad_range
      $error("led_seq_stepper: FIRST must be below LAST");
   end
   if (longint'(LAST) >= (longint'(1) << STATE_W)) begin : g_bad_width
      $error("led_seq_stepper: LAST does not fit in STATE_W bits");
   end

   logic [STATE_W-1:0] r_state;
   dir_e               r_dir;
   logic               r_step_tick;
   logic               r_wrap;

   logic [STATE_W-1:0] w_state_nxt;
   dir_e               w_dir_nxt;
   logic               w_step_tick_nxt;
   logic               w_wrap_nxt;
   logic [STATE_W-1:0] w_pp_state;
   logic               w_tick;
   logic               w_step;
   logic               w_out_of_range;

   led_seq_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .clr  (restart),
      .tick (w_tick)
   );

`ifdef LED_SEQ_MANUAL_STEP_EN
   // Manual step only counts while the prescaler is stopped
   assign w_step = w_tick | (~en & step_req);
`else
   assign w_step = w_tick;
`endif

   assign w_out_of_range = (r_state < S_FIRST) || (r_state > S_LAST);

   // Next state, direction and pulse outputs; restart overrides any step
   always_comb begin
      w_state_nxt     = r_state;
      w_dir_nxt       = r_dir;
      w_step_tick_nxt = 1'b0;
      w_wrap_nxt      = 1'b0;
      w_pp_state      = r_state;

      if (restart) begin
         w_state_nxt = S_FIRST;
         w_dir_nxt   = DIR_UP;
      end else if (w_step && (mode_e'(mode) != MODE_HOLD)) begin
         w_step_tick_nxt = 1'b1;
         if (w_out_of_range) begin
            w_state_nxt = S_FIRST;
            w_dir_nxt   = DIR_UP;
         end else begin
            case (mode_e'(mode))
               MODE_UP: begin
                  if (r_state == S_LAST) begin
                     w_state_nxt = S_FIRST;
                     w_wrap_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = r_state + STATE_W'(1);
                  end
               end
               MODE_DOWN: begin
                  if (r_state == S_FIRST) begin
                     w_state_nxt = S_LAST;
                     w_wrap_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = r_state - STATE_W'(1);
                  end
               end
               MODE_PINGPONG: begin
                  // A stale direction pointing out of range (left over from
                  // another mode) bounces back instead of stepping outside.
                  if (r_dir == DIR_UP) begin
                     w_pp_state = (r_state == S_LAST) ? r_state - STATE_W'(1)
                                                      : r_state + STATE_W'(1);
                  end else begin
                     w_pp_state = (r_state == S_FIRST) ? r_state + STATE_W'(1)
                                                       : r_state - STATE_W'(1);
                  end
                  w_state_nxt = w_pp_state;
                  if (w_pp_state == S_LAST) begin
                     w_dir_nxt  = DIR_DOWN;
                     w_wrap_nxt = 1'b1;
                  end else if (w_pp_state == S_FIRST) begin
                     w_dir_nxt  = DIR_UP;
                     w_wrap_nxt = 1'b1;
                  end else begin
                     w_dir_nxt = (w_pp_state > r_state) ? DIR_UP : DIR_DOWN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // State, direction and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FIRST;
         r_dir       <= DIR_UP;
         r_step_tick <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_dir       <= w_dir_nxt;
         r_step_tick <= w_step_tick_nxt;
         r_wrap      <= w_wrap_nxt;
      end
   end

   assign state     = r_state;
   assign step_tick = r_step_tick;
   assign wrap      = r_wrap;

   // State must always sit inside the programmed range
   a_state_in_range: assert property (@(posedge clk) disable iff (rst)
      (r_state >= S_FIRST) && (r_state <= S_LAST));

endmodule

// File: tb/tb_led_seq_stepper.sv
// Directed bench for led_seq_stepper with TICK_DIV=4, FIRST=11, LAST=14,
// plus a TICK_DIV=1 instance for the every-cycle case.
module tb_led_seq_stepper;
   import led_seq_pkg::*;

   localparam int unsigned TD = 4;
   localparam int unsigned SW = 8;
   localparam int unsigned FI = 11;
   localparam int unsigned LA = 14;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          en       = 1'b0;
   logic          restart  = 1'b0;
   logic [1:0]    mode     = 2'b00;
   logic          rst1     = 1'b1;
   logic          en1      = 1'b0;
   logic          restart1 = 1'b0;
   logic [SW-1:0] state;
   logic [SW-1:0] state1;
   logic          step_tick;
   logic          step_tick1;
   logic          wrap;
   logic          wrap1;
`ifdef LED_SEQ_MANUAL_STEP_EN
   logic          step_req = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   led_seq_stepper #(.TICK_DIV(TD), .STATE_W(SW), .FIRST(FI), .LAST(LA)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef LED_SEQ_MANUAL_STEP_EN
      .step_req  (step_req),
`endif
      .en        (en),
      .mode      (mode),
      .restart   (restart),
      .state     (state),
      .step_tick (step_tick),
      .wrap      (wrap)
   );

   led_seq_stepper #(.TICK_DIV(1), .STATE_W(SW), .FIRST(FI), .LAST(LA)) dut1 (
      .clk       (clk),
      .rst       (rst1),
`ifdef LED_SEQ_MANUAL_STEP_EN
      .step_req  (1'b0),
`endif
      .en        (en1),
      .mode      (mode),
      .restart   (restart1),
      .state     (state1),
      .step_tick (step_tick1),
      .wrap      (wrap1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reset the main DUT with a given mode and release it with en=1 at a falling edge
   task automatic do_reset(input logic [1:0] m);
      @(negedge clk);
      rst     = 1'b1;
      en      = 1'b0;
      restart = 1'b0;
      mode    = m;
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
   endtask

   // Wait (bounded) for the next step_tick and check its spacing, state and wrap
   task automatic wait_step(input string tag, input int exp_cyc, input int exp_state,
                            input logic exp_wrap);
      int   cyc   = 0;
      logic seen  = 1'b0;
      logic stray = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (step_tick) seen = 1'b1;
         else if (wrap) stray = 1'b1;
      end
      check($sformatf("%s/cycles", tag), cyc, exp_cyc);
      check($sformatf("%s/state", tag), 32'(state), exp_state);
      check($sformatf("%s/wrap", tag), 32'(wrap), 32'(exp_wrap));
      check($sformatf("%s/stray_wrap", tag), 32'(stray), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;

      // Reset values while rst is held
      @(negedge clk);
      check("reset/state", 32'(state), FI);
      check("reset/step_tick", 32'(step_tick), 0);
      check("reset/wrap", 32'(wrap), 0);

      // Up mode: 12,13,14,11 with wrap only on 14->11
      do_reset(MODE_UP);
      wait_step("up1", 4, 12, 1'b0);
      wait_step("up2", 4, 13, 1'b0);
      wait_step("up3", 4, 14, 1'b0);
      wait_step("up4", 4, 11, 1'b1);
      // Async reset while wrap is high clears it without a clock edge
      #1 rst = 1'b1;
      #1;
      check("arst/wrap", 32'(wrap), 0);
      check("arst/state_after_wrap", 32'(state), FI);

      // Down mode: 14 with wrap, then 13,12,11
      do_reset(MODE_DOWN);
      wait_step("dn1", 4, 14, 1'b1);
      wait_step("dn2", 4, 13, 1'b0);
      wait_step("dn3", 4, 12, 1'b0);
      wait_step("dn4", 4, 11, 1'b0);

      // Ping-pong: 12,13,14(w),13,12,11(w),12
      do_reset(MODE_PINGPONG);
      wait_step("pp1", 4, 12, 1'b0);
      wait_step("pp2", 4, 13, 1'b0);
      wait_step("pp3", 4, 14, 1'b1);
      wait_step("pp4", 4, 13, 1'b0);
      wait_step("pp5", 4, 12, 1'b0);
      wait_step("pp6", 4, 11, 1'b1);
      wait_step("pp7", 4, 12, 1'b0);

      // Enable dropped with prescaler at 2 for 10 cycles, then resume
      do_reset(MODE_UP);
      repeat (2) @(negedge clk);
      en   = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (step_tick) seen++;
      end
      check("freeze/state", 32'(state), FI);
      check("freeze/steps", seen, 0);
      en = 1'b1;
      wait_step("resume", 2, 12, 1'b0);

      // Restart coinciding with the tick out of state 13
      do_reset(MODE_UP);
      wait_step("rs1", 4, 12, 1'b0);
      wait_step("rs2", 4, 13, 1'b0);
      repeat (3) @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check("restart/state", 32'(state), FI);
      check("restart/step_tick", 32'(step_tick), 0);
      check("restart/wrap", 32'(wrap), 0);
      wait_step("rs3", 4, 12, 1'b0);
      // Async reset mid-sequence while step_tick is high
      #1 rst = 1'b1;
      #1;
      check("arst/state", 32'(state), FI);
      check("arst/step_tick", 32'(step_tick), 0);

      // Hold: no steps while the prescaler keeps running, then up from count 1
      do_reset(MODE_HOLD);
      seen = 0;
      repeat (13) begin
         @(negedge clk);
         if (step_tick || wrap) seen++;
      end
      check("hold/state", 32'(state), FI);
      check("hold/pulses", seen, 0);
      mode = MODE_UP;
      wait_step("hold_up", 3, 12, 1'b0);

`ifdef LED_SEQ_MANUAL_STEP_EN
      // Manual steps with en=0, then step_req ignored with en=1
      do_reset(MODE_UP);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_req = 1'b1;
         @(negedge clk);
         step_req = 1'b0;
         check($sformatf("man%0d/state", i), 32'(state), FI + 1 + i);
         check($sformatf("man%0d/step_tick", i), 32'(step_tick), 1);
         check($sformatf("man%0d/wrap", i), 32'(wrap), 0);
      end
      do_reset(MODE_UP);
      step_req = 1'b1;
      repeat (2) @(negedge clk);
      step_req = 1'b0;
      check("man_en/state", 32'(state), FI);
`endif

      // TICK_DIV=1: a step on every enabled cycle
      @(negedge clk);
      mode = MODE_UP;
      rst1 = 1'b0;
      en1  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("td1_%0d/state", i), 32'(state1), (i == 3) ? FI : FI + 1 + i);
         check($sformatf("td1_%0d/step_tick", i), 32'(step_tick1), 1);
         check($sformatf("td1_%0d/wrap", i), 32'(wrap1), (i == 3) ? 1 : 0);
      end
      en1 = 1'b0;
      @(negedge clk);
      check("td1_off/step_tick", 32'(step_tick1), 0);
      check("td1_off/state", 32'(state1), FI);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
